pma_checker: RTL and testbench
==============================

Name: pma_checker

Overview:
- Parametrised physical-memory-attribute checker; successor to the fixed five-entry static PMA map.
- Holds NUM_REGIONS runtime-programmable regions (base, size, attributes, lock).
- Serves one lookup per cycle through a valid/ready pipeline and returns region index, MMIO flag and access-fault verdict.
- Sits between address translation and the LSU/fetch device router.

Parameters:
- NUM_REGIONS, 8, number of region entries; minimum 5.
- PADDR_WIDTH, 56, physical address width.
- IDX_WIDTH, $clog2(NUM_REGIONS), region index width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  lookup request valid
- req_ready  out  1  lookup request accepted when high with req_valid
- req_paddr  in  PADDR_WIDTH  physical address to check
- req_acc  in  2  access type: 0=read, 1=write, 2=execute, 3=reserved (always faults)
- resp_valid  out  1  response valid
- resp_ready  in  1  consumer accepts response
- resp_hit  out  1  address matched an enabled region
- resp_idx  out  IDX_WIDTH  matching region index; 0 when no hit
- resp_mmio  out  1  matching region is MMIO; 0 when no hit
- resp_fault  out  1  no hit, or permission bit for req_acc clear, or req_acc==3
- cfg_we  in  1  region table write strobe
- cfg_idx  in  IDX_WIDTH  entry to write
- cfg_base  in  PADDR_WIDTH  new base
- cfg_size  in  PADDR_WIDTH  new size in bytes
- cfg_attr  in  5  {lock, x, w, r, mmio}
- cfg_err  out  1  one-cycle pulse: write rejected (locked entry or cfg_idx>=NUM_REGIONS)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset table contents:
  - entry0 0x0000_1000/0x0100_0000 r,x
  - entry1 0x0200_0000/0x0001_0000 mmio,r,w
  - entry2 0x0C00_0000/0x0400_0000 mmio,r,w
  - entry3 0x1000_0000/0x0000_0100 mmio,r,w
  - entry4 0x8000_0000/0x8800_0000 r,w,x
  - remaining entries size 0 (disabled); no entries locked.
- Reset outputs: resp_valid=0, resp_hit=0, resp_idx=0, resp_mmio=0, resp_fault=0, cfg_err=0. req_ready is 1 one cycle after reset release.
- Match rule: base <= paddr < base+size. The sum is computed in PADDR_WIDTH+1 bits, so no wrap; entry 4's end is 0x1_0800_0000.
- size==0 never matches. Lowest matching index wins on overlap.
- Pipeline: one register stage, latency 1 cycle. The lookup result is registered when req_valid && req_ready.
- req_ready = !resp_valid || resp_ready. Full throughput when resp_ready is held high.
- Response stall: while resp_valid && !resp_ready, all resp_* outputs hold stable and req_ready=0.
- Config write, accepted case: a write to an unlocked, in-range index updates the entry at the clock edge.
- Config write, rejected case: a locked or out-of-range index leaves the table unchanged and cfg_err=1 for the following cycle.
- Lock: setting lock makes the entry immutable until rst_n assertion.
- Same-cycle cfg_we and accepted request: the lookup uses the pre-write table; a request the next cycle sees the new value.
- Reset mid-operation: an in-flight response is dropped and the table returns to reset contents.

Optional Feature:
- Macro: PMA_FAULT_CAPTURE_EN.
- When defined, adds these ports:
  - fault_valid  out  1
  - fault_addr  out  PADDR_WIDTH
  - fault_acc  out  2
  - fault_clr  in  1
- Capture rule: on the first accepted request producing resp_fault=1 while fault_valid=0, paddr and acc are latched and fault_valid is set the same cycle resp_valid rises.
- Later faults are ignored until fault_clr. fault_clr has priority over a simultaneous new fault, which is not captured.
- All fault_* registers reset to 0.
- Without the macro: no extra ports and no capture logic.

Test Plan:
- After reset, read of 0x8000_0000, then 0x1_07FF_FFFF, then 0x1_0800_0000 -> first two: hit=1, idx=4, mmio=0, fault=0. Third: hit=0, fault=1.
- Write to 0x1000_0010 -> idx=3, mmio=1, fault=0. Execute at 0x1000_0010 -> fault=1 (x clear).
- resp_ready=0 for 3 cycles with back-to-back requests 0x0200_0000, 0x0C00_0000 -> first response held stable, req_ready=0, second accepted only after resp_ready=1, responses in order, none lost.
- Program entry5 base 0x9000_0000 size 0x1000 attr {lock,r}, then rewrite entry5 -> second write gives cfg_err pulse. Read 0x9000_0800 -> idx=4, not 5, because of lower-index priority.
- cfg_we to entry4 (size 0) in the same cycle as a read of 0x8000_0000 -> that response has hit=1; the next-cycle read of 0x8000_0000 gives fault=1.
- With PMA_FAULT_CAPTURE_EN: faults at 0x0 then 0x2000_0000 -> fault_addr=0x0 held. fault_clr, then fault at 0x3000_0000 -> fault_addr=0x3000_0000.

Source files
------------

// File: rtl/pma_checker.sv
// pma_checker: runtime-programmable physical memory attribute checker.
//
// Holds NUM_REGIONS regions, each with a base, a size, attributes and a lock bit.
// Each cycle it accepts one lookup through a valid/ready handshake. The result is
// registered, so it appears one cycle later, and it holds while the consumer stalls.
//
// Ports
//   clk, rst_n                 clock and asynchronous active-low reset
//   req_valid/req_ready        lookup handshake
//   req_paddr, req_acc         address; access type (0 rd, 1 wr, 2 exec, 3 reserved)
//   resp_valid/resp_ready      response handshake
//   resp_hit/idx/mmio/fault    lookup verdict
//   cfg_we/idx/base/size/attr  region write port; attr = {lock, x, w, r, mmio}
//   cfg_err                    one-cycle pulse when a region write is rejected
//
// Optional feature (macro PMA_FAULT_CAPTURE_EN)
//   fault_valid/addr/acc       the first faulting request, held until it is cleared
//   fault_clr                  clears the capture; it wins over a fault in the same cycle
module pma_checker #(
  parameter int unsigned NUM_REGIONS = 8,
  parameter int unsigned PADDR_WIDTH = 56,
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGIONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PADDR_WIDTH-1:0] req_paddr,
  input  logic [1:0]             req_acc,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_hit,
  output logic [IDX_WIDTH-1:0]   resp_idx,
  output logic                   resp_mmio,
  output logic                   resp_fault,
  input  logic                   cfg_we,
  input  logic [IDX_WIDTH-1:0]   cfg_idx,
  input  logic [PADDR_WIDTH-1:0] cfg_base,
  input  logic [PADDR_WIDTH-1:0] cfg_size,
  input  logic [4:0]             cfg_attr,
  output logic                   cfg_err
`ifdef PMA_FAULT_CAPTURE_EN
  ,
  output logic                   fault_valid,
  output logic [PADDR_WIDTH-1:0] fault_addr,
  output logic [1:0]             fault_acc,
  input  logic                   fault_clr
`endif
);

  localparam int unsigned AttrLock = 4;
  localparam int unsigned AttrX    = 3;
  localparam int unsigned AttrW    = 2;
  localparam int unsigned AttrR    = 1;
  localparam int unsigned AttrMmio = 0;

  // Reset contents of the region table; entries 5 and up have size 0, so they are disabled.
  function automatic logic [PADDR_WIDTH-1:0] rst_base(int unsigned i);
    case (i)
      0:       return PADDR_WIDTH'(64'h0000_1000);
      1:       return PADDR_WIDTH'(64'h0200_0000);
      2:       return PADDR_WIDTH'(64'h0C00_0000);
      3:       return PADDR_WIDTH'(64'h1000_0000);
      4:       return PADDR_WIDTH'(64'h8000_0000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [PADDR_WIDTH-1:0] rst_size(int unsigned i);
    case (i)
      0:       return PADDR_WIDTH'(64'h0100_0000);
      1:       return PADDR_WIDTH'(64'h0001_0000);
      2:       return PADDR_WIDTH'(64'h0400_0000);
      3:       return PADDR_WIDTH'(64'h0000_0100);
      4:       return PADDR_WIDTH'(64'h8800_0000);
      default: return '0;
    endcase
  endfunction

  function automatic logic [4:0] rst_attr(int unsigned i);
    case (i)
      0:       return 5'b0_1010;  // r, x
      1:       return 5'b0_0111;  // mmio, r, w
      2:       return 5'b0_0111;
      3:       return 5'b0_0111;
      4:       return 5'b0_1110;  // r, w, x
      default: return 5'b0_0000;
    endcase
  endfunction

  logic [PADDR_WIDTH-1:0] base_q [NUM_REGIONS];
  logic [PADDR_WIDTH-1:0] size_q [NUM_REGIONS];
  logic [4:0]             attr_q [NUM_REGIONS];

  // Region table and its write port
  logic cfg_in_range, cfg_reject, cfg_accept, cfg_err_q;

  assign cfg_in_range = 32'(cfg_idx) < NUM_REGIONS;
  assign cfg_reject   = cfg_we && (!cfg_in_range || attr_q[cfg_idx][AttrLock]);
  assign cfg_accept   = cfg_we && !cfg_reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
        base_q[i] <= rst_base(i);
        size_q[i] <= rst_size(i);
        attr_q[i] <= rst_attr(i);
      end
      cfg_err_q <= 1'b0;
    end else begin
      if (cfg_accept) begin
        base_q[cfg_idx] <= cfg_base;
        size_q[cfg_idx] <= cfg_size;
        attr_q[cfg_idx] <= cfg_attr;
      end
      cfg_err_q <= cfg_reject;
    end
  end

  assign cfg_err = cfg_err_q;

  // Lookup. The end of each region is computed one bit wider than the address, so a
  // region that reaches the top of the address space does not wrap around to zero.
  logic [NUM_REGIONS-1:0] match;
  logic                   lk_hit, lk_perm, lk_fault;
  logic [IDX_WIDTH-1:0]   lk_idx;
  logic [4:0]             lk_attr;

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
      match[i] = (size_q[i] != '0) && (req_paddr >= base_q[i]) &&
                 ({1'b0, req_paddr} < ({1'b0, base_q[i]} + {1'b0, size_q[i]}));
    end
  end

  // Scan from the top entry down, so that when regions overlap the lowest index wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_attr = '0;
    for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_WIDTH'(i);
        lk_attr = attr_q[i];
      end
    end
  end

  always_comb begin
    case (req_acc)
      2'd0:    lk_perm = lk_attr[AttrR];
      2'd1:    lk_perm = lk_attr[AttrW];
      2'd2:    lk_perm = lk_attr[AttrX];
      default: lk_perm = 1'b0;
    endcase
    lk_fault = !lk_hit || !lk_perm;
  end

  // Response register stage. init_q holds req_ready low until one clock after reset is released.
  logic                 init_q, resp_valid_q, resp_hit_q, resp_mmio_q, resp_fault_q;
  logic [IDX_WIDTH-1:0] resp_idx_q;
  logic                 req_fire;

  assign req_ready = init_q && (!resp_valid_q || resp_ready);
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_idx_q   <= '0;
      resp_mmio_q  <= 1'b0;
      resp_fault_q <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (req_fire) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= lk_hit;
        resp_idx_q   <= lk_idx;
        resp_mmio_q  <= lk_hit && lk_attr[AttrMmio];
        resp_fault_q <= lk_fault;
      end else if (resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_idx   = resp_idx_q;
  assign resp_mmio  = resp_mmio_q;
  assign resp_fault = resp_fault_q;

`ifdef PMA_FAULT_CAPTURE_EN
  logic                   fault_valid_q;
  logic [PADDR_WIDTH-1:0] fault_addr_q;
  logic [1:0]             fault_acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_acc_q   <= '0;
    end else if (fault_clr) begin
      fault_valid_q <= 1'b0;
    end else if (req_fire && lk_fault && !fault_valid_q) begin
      fault_valid_q <= 1'b1;
      fault_addr_q  <= req_paddr;
      fault_acc_q   <= req_acc;
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_acc   = fault_acc_q;
`endif

endmodule

// File: tb/tb_pma_checker.sv
// Self-checking bench for pma_checker. A behavioural model of the region table and a
// queue of expected responses predict every output. Directed cases are followed by a
// randomized run.
module tb_pma_checker;
  localparam int unsigned NR = 8;
  localparam int unsigned AW = 56;
  localparam longint unsigned AMASK = (64'h1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready;
  logic [AW-1:0] req_paddr = '0;
  logic [1:0]    req_acc = '0;
  logic          resp_valid, resp_ready = 1'b1;
  logic          resp_hit, resp_mmio, resp_fault;
  logic [2:0]    resp_idx;
  logic          cfg_we = 1'b0;
  logic [2:0]    cfg_idx = '0;
  logic [AW-1:0] cfg_base = '0, cfg_size = '0;
  logic [4:0]    cfg_attr = '0;
  logic          cfg_err;
`ifdef PMA_FAULT_CAPTURE_EN
  logic          fault_valid, fault_clr = 1'b0;
  logic [AW-1:0] fault_addr;
  logic [1:0]    fault_acc;
  logic          fm_valid;
  logic [AW-1:0] fm_addr;
  logic [1:0]    fm_acc;
`endif

  pma_checker #(.NUM_REGIONS(NR), .PADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_paddr(req_paddr), .req_acc(req_acc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_idx(resp_idx), .resp_mmio(resp_mmio), .resp_fault(resp_fault),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_base(cfg_base), .cfg_size(cfg_size),
    .cfg_attr(cfg_attr), .cfg_err(cfg_err)
`ifdef PMA_FAULT_CAPTURE_EN
    , .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_acc(fault_acc),
    .fault_clr(fault_clr)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model. A response is packed as {hit, idx[2:0], mmio, fault}.
  longint unsigned m_base[NR];
  longint unsigned m_size[NR];
  logic [4:0]      m_attr[NR];
  logic [5:0]      exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_base[i] = 0; m_size[i] = 0; m_attr[i] = 5'b0;
    end
    m_base[0] = 64'h0000_1000; m_size[0] = 64'h0100_0000; m_attr[0] = 5'b01010;
    m_base[1] = 64'h0200_0000; m_size[1] = 64'h0001_0000; m_attr[1] = 5'b00111;
    m_base[2] = 64'h0C00_0000; m_size[2] = 64'h0400_0000; m_attr[2] = 5'b00111;
    m_base[3] = 64'h1000_0000; m_size[3] = 64'h0000_0100; m_attr[3] = 5'b00111;
    m_base[4] = 64'h8000_0000; m_size[4] = 64'h8800_0000; m_attr[4] = 5'b01110;
    exp_q.delete();
`ifdef PMA_FAULT_CAPTURE_EN
    fm_valid = 1'b0; fm_addr = '0; fm_acc = '0;
`endif
  endtask

  function automatic logic [5:0] model_lookup(input longint unsigned a, input logic [1:0] acc);
    for (int i = 0; i < NR; i++) begin
      if (m_size[i] != 0 && a >= m_base[i] && a < m_base[i] + m_size[i]) begin
        logic ok;
        ok = (acc == 2'd0) ? m_attr[i][1] : (acc == 2'd1) ? m_attr[i][2] :
             (acc == 2'd2) ? m_attr[i][3] : 1'b0;
        return {1'b1, 3'(i), m_attr[i][0], !ok};
      end
    end
    return 6'b0_000_0_1;
  endfunction

  // One clock cycle. Inputs are already driven at the negedge. Check outputs, advance the
  // model, cross the posedge and check the registered side outputs.
  task automatic cycle();
    logic exp_rdy, fire, exp_err;
    logic [5:0] lk;
    #1;
    exp_rdy = (exp_q.size() == 0) || resp_ready;
    check("req_ready", {63'b0, req_ready}, {63'b0, exp_rdy});
    check("resp_valid", {63'b0, resp_valid}, {63'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("resp", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, {58'b0, exp_q[0]});
      if (resp_ready) void'(exp_q.pop_front());
    end
    fire = req_valid && exp_rdy;
    lk = model_lookup(64'(req_paddr), req_acc);
    if (fire) exp_q.push_back(lk);
`ifdef PMA_FAULT_CAPTURE_EN
    if (fault_clr) fm_valid = 1'b0;
    else if (fire && lk[0] && !fm_valid) begin
      fm_valid = 1'b1; fm_addr = req_paddr; fm_acc = req_acc;
    end
`endif
    exp_err = cfg_we && m_attr[cfg_idx][4];
    if (cfg_we && !exp_err) begin
      m_base[cfg_idx] = 64'(cfg_base); m_size[cfg_idx] = 64'(cfg_size);
      m_attr[cfg_idx] = cfg_attr;
    end
    @(posedge clk);
    @(negedge clk);
    check("cfg_err", {63'b0, cfg_err}, {63'b0, exp_err});
`ifdef PMA_FAULT_CAPTURE_EN
    check("fault_valid", {63'b0, fault_valid}, {63'b0, fm_valid});
    check("fault_addr", 64'(fault_addr), 64'(fm_addr));
    check("fault_acc", {62'b0, fault_acc}, {62'b0, fm_acc});
`endif
  endtask

  // Issue one request and drain it; r is the response seen one cycle later.
  task automatic lookup(input longint unsigned a, input logic [1:0] acc, output logic [5:0] r);
    req_valid = 1'b1; req_paddr = AW'(a); req_acc = acc; resp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    r = {resp_hit, resp_idx, resp_mmio, resp_fault};
    cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_resp_fields", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, 64'd0);
    check("rst_cfg_err", {63'b0, cfg_err}, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", {63'b0, req_ready}, 64'd1);
  endtask

  logic [5:0] r;

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Boundary of entry 4, whose end lies above 32 bits
    lookup(64'h8000_0000, 2'd0, r);    check("e4_base", 64'(r), 64'b1_100_0_0);
    lookup(64'h1_07FF_FFFF, 2'd0, r);  check("e4_last", 64'(r), 64'b1_100_0_0);
    lookup(64'h1_0800_0000, 2'd0, r);  check("e4_end", 64'(r), 64'b0_000_0_1);
    lookup(64'h1000_0010, 2'd1, r);    check("e3_write", 64'(r), 64'b1_011_1_0);
    lookup(64'h1000_0010, 2'd2, r);    check("e3_exec", 64'(r), 64'b1_011_1_1);
    lookup(64'h0000_1000, 2'd3, r);    check("acc_rsvd", 64'(r), 64'b1_000_0_1);

    // Stall with back-to-back requests
    resp_ready = 1'b0; req_valid = 1'b1; req_paddr = AW'(64'h0200_0000); req_acc = 2'd0;
    cycle();
    req_paddr = AW'(64'h0C00_0000);
    for (int i = 0; i < 3; i++) cycle();
    check("stall_ready", {63'b0, req_ready}, 64'd0);
    check("stall_head", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, 64'b1_001_1_0);
    resp_ready = 1'b1;
    cycle();
    req_valid = 1'b0;
    check("stall_second", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, 64'b1_010_1_0);
    cycle();

    // Lock entry 5, then try to rewrite it
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_base = AW'(64'h9000_0000); cfg_size = AW'(64'h1000);
    cfg_attr = 5'b10010;
    cycle();
    cfg_base = '0; cfg_attr = 5'b00010;
    cycle();
    check("lock_err", {63'b0, cfg_err}, 64'd1);
    cfg_we = 1'b0;
    cycle();
    check("err_pulse", {63'b0, cfg_err}, 64'd0);
    lookup(64'h9000_0800, 2'd0, r);    check("overlap_prio", 64'(r), 64'b1_100_0_0);

    // A write in the same cycle as a lookup: the lookup sees the old table
    cfg_we = 1'b1; cfg_idx = 3'd4; cfg_base = AW'(64'h8000_0000); cfg_size = '0;
    cfg_attr = 5'b01110;
    req_valid = 1'b1; req_paddr = AW'(64'h8000_0000); req_acc = 2'd0;
    cycle();
    cfg_we = 1'b0;
    check("same_cycle_old", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, 64'b1_100_0_0);
    cycle();
    check("next_cycle_new", {58'b0, resp_hit, resp_idx, resp_mmio, resp_fault}, 64'b0_000_0_1);

    // Reset while a response is stalled
    resp_ready = 1'b0;
    cycle();
    req_valid = 1'b0; resp_ready = 1'b1;
    do_reset();
    lookup(64'h8000_0000, 2'd0, r);    check("table_restored", 64'(r), 64'b1_100_0_0);

`ifdef PMA_FAULT_CAPTURE_EN
    lookup(64'h0, 2'd0, r);
    lookup(64'h2000_0000, 2'd1, r);
    check("cap_first", 64'(fault_addr), 64'h0);
    fault_clr = 1'b1;
    cycle();
    fault_clr = 1'b0;
    lookup(64'h3000_0000, 2'd0, r);
    check("cap_after_clr", 64'(fault_addr), 64'h3000_0000);
`endif

    // Randomized run with a reset in the middle
    for (int n = 0; n < 3000; n++) begin
      int unsigned k;
      longint unsigned a;
      if (n == 1500) do_reset();
      k = $urandom_range(0, NR - 1);
      case ($urandom_range(0, 4))
        0:       a = m_base[k] - 1;
        1:       a = m_base[k];
        2:       a = m_base[k] + m_size[k] - 1;
        3:       a = m_base[k] + m_size[k];
        default: a = {32'b0, $urandom};
      endcase
      req_valid  = ($urandom_range(0, 9) < 7);
      req_paddr  = AW'(a & AMASK);
      req_acc    = 2'($urandom_range(0, 3));
      resp_ready = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 15) == 0);
      cfg_idx    = 3'($urandom_range(0, NR - 1));
      cfg_base   = AW'({32'b0, $urandom & 32'hFFFF_F000});
      cfg_size   = AW'(64'($urandom_range(0, 4)) << 12);
      cfg_attr   = {($urandom_range(0, 7) == 0), 4'($urandom)};
`ifdef PMA_FAULT_CAPTURE_EN
      fault_clr  = ($urandom_range(0, 9) == 0);
`endif
      cycle();
    end
    req_valid = 1'b0; cfg_we = 1'b0; resp_ready = 1'b1;
`ifdef PMA_FAULT_CAPTURE_EN
    fault_clr = 1'b0;
`endif
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
